// File: rtl/act_lut_writer.sv
// act_lut_writer: streams activation (tanh) table entries into the LUT RAM write port,
// checks the load length and flags a complete, good table via lut_valid.
// Optional feature macro: LUT_CRC_EN (adds a trailing checksum beat compared against
// the modulo-2**DW sum of all entries).
module act_lut_writer #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          lut_we,
  output logic [AW-1:0] lut_addr,
  output logic [DW-1:0] lut_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          lut_valid
);

  // Index of the final table entry; counter is one bit wider so it never wraps.
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

`ifdef LUT_CRC_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHK} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          accept;
  logic          is_final;
`ifdef LUT_CRC_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  // Next-state, write-port and status computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef LUT_CRC_EN
    sum_d    = sum_q;
`endif
    accept   = s_valid && s_ready_q;
    is_final = (cnt_q == LAST_IDX);

    if (start) begin
      // Restart wins over any beat offered in the same cycle.
      state_d = ST_LOAD;
      cnt_d   = '0;
      err_d   = 1'b0;
      valid_d = 1'b0;
`ifdef LUT_CRC_EN
      sum_d   = '0;
`endif
    end else if (accept) begin
      case (state_q)
        ST_LOAD: begin
`ifdef LUT_CRC_EN
          if (s_last) begin
            // Entries end early (the checksum beat is the real final beat).
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[AW-1:0];
            wdata_d = s_data;
            sum_d   = sum_q + s_data;
            if (is_final) state_d = ST_CHK;
            else          cnt_d   = cnt_q + (AW+1)'(1);
          end
`else
          if (s_last && !is_final) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[AW-1:0];
            wdata_d = s_data;
            if (is_final) begin
              state_d = ST_IDLE;
              if (s_last) begin
                done_d  = 1'b1;
                valid_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                valid_d = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + (AW+1)'(1);
            end
          end
`endif
        end
`ifdef LUT_CRC_EN
        ST_CHK: begin
          // Checksum beat: never written to the RAM.
          state_d = ST_IDLE;
          if (s_last && (s_data == sum_q)) begin
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            valid_d = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end

    s_ready_d = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef LUT_CRC_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
`ifdef LUT_CRC_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign lut_we    = we_q;
  assign lut_addr  = addr_q;
  assign lut_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign lut_valid = valid_q;

endmodule
